// File: rtl/cla_addsub_seq.sv
// Multi-cycle carry-lookahead adder/subtractor: one SLICE-bit lookahead group per clock,
// with the inter-slice carry held in a register and a start/busy/ready handshake.
module cla_addsub_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic             c_in,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             ready
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CntW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NSLICE - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d, ovf_q, ovf_d, zero_q, zero_d, ready_q, ready_d;
  logic             accept, last;

  logic [SLICE-1:0] s_a, s_b, s_g, s_p, s_sum;
  logic [SLICE:0]   s_c;
  logic             acc, pp;
  int unsigned      base;

  assign accept = start && (state_q != StCalc);
  assign last   = (state_q == StCalc) && (cnt_q == LastCnt);

  // Slice carries are fully expanded from the slice carry-in: no ripple inside the group.
  always_comb begin
    base   = 32'(cnt_q) * SLICE;
    s_a    = a_q[base +: SLICE];
    s_b    = b_q[base +: SLICE];
    s_g    = s_a & s_b;
    s_p    = s_a | s_b;
    s_c    = '0;
    s_c[0] = carry_q;
    acc    = 1'b0;
    pp     = 1'b1;
    for (int i = 0; i < SLICE; i++) begin
      acc = 1'b0;
      pp  = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc = acc | (pp & s_g[j]);
        pp  = pp & s_p[j];
      end
      s_c[i+1] = acc | (pp & carry_q);
    end
    s_sum = s_a ^ s_b ^ s_c[SLICE-1:0];
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    ready_d  = 1'b0;
    if (accept) begin
      a_d      = A;
      b_d      = mode ? ~B : B;
      carry_d  = mode ? ~c_in : c_in;
      cnt_d    = '0;
      result_d = '0;
    end else if (state_q == StCalc) begin
      result_d[base +: SLICE] = s_sum;
      carry_d = s_c[SLICE];
      cnt_d   = cnt_q + 1'b1;
      if (last) begin
        cnt_d   = '0;
        c_out_d = s_c[SLICE];
        ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (result_d[WIDTH-1] != a_q[WIDTH-1]);
        zero_d  = (result_d == '0);
        ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StCalc;
      StCalc:         if (cnt_q == LastCnt) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    busy   = (state_q == StCalc);
    ready  = ready_q;
    result = result_q;
    c_out  = c_out_q;
    ovf    = ovf_q;
    zero   = zero_q;
  end

endmodule

// File: tb/tb_cla_addsub_seq.sv
// Bench for cla_addsub_seq: 8-bit and 16-bit instances, vector table, handshake/reset
// sequences and random ops against an arithmetic reference model via scoreboards.
module tb_cla_addsub_seq;

  typedef struct {
    logic [15:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  typedef struct {
    logic       mode;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       cout;
    logic       ovf;
    logic       zero;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start8 = 1'b0, start16 = 1'b0, mode = 1'b0, c_in = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic [7:0]  r8;
  logic [15:0] r16;
  logic        co8, ov8, z8, busy8, rdy8, co16, ov16, z16, busy16, rdy16;

  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_rdy_cyc = 0;
  exp_t q8[$];
  exp_t q16[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cla_addsub_seq #(.WIDTH(8), .SLICE(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode), .c_in(c_in),
    .A(a[7:0]), .B(b[7:0]), .result(r8), .c_out(co8), .ovf(ov8), .zero(z8),
    .busy(busy8), .ready(rdy8)
  );

  cla_addsub_seq #(.WIDTH(16), .SLICE(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode), .c_in(c_in),
    .A(a), .B(b), .result(r16), .c_out(co16), .ovf(ov16), .zero(z16),
    .busy(busy16), .ready(rdy16)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Independent arithmetic reference: integer add/sub, borrow and signed range test.
  function automatic exp_t model(input int w, input logic m, input logic ci,
                                 input logic [15:0] aa, input logic [15:0] bb);
    exp_t   r;
    longint mask, ua, ub, sa, sb, u, s, lc;
    mask = (longint'(1) << w) - 1;
    ua = longint'({48'd0, aa}) & mask;
    ub = longint'({48'd0, bb}) & mask;
    sa = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
    sb = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
    lc = ci ? 1 : 0;
    if (!m) begin
      u = ua + ub + lc;
      s = sa + sb + lc;
      r.cout = ((u >> w) & 1) != 0;
    end else begin
      u = ua - ub - lc;
      s = sa - sb - lc;
      r.cout = (u >= 0);
    end
    r.res  = 16'(u & mask);
    r.ovf  = (s > ((longint'(1) << (w - 1)) - 1)) || (s < -(longint'(1) << (w - 1)));
    r.zero = ((u & mask) == 0);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rdy8) begin
      if (q8.size() == 0) begin
        check("unexpected_ready8", 16'(rdy8), 16'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("res8", {8'h00, r8}, e.res);
        check("cout8", 16'(co8), 16'(e.cout));
        check("ovf8", 16'(ov8), 16'(e.ovf));
        check("zero8", 16'(z8), 16'(e.zero));
      end
    end
  end

  always @(negedge clk) begin
    if (rdy16) begin
      if (q16.size() == 0) begin
        check("unexpected_ready16", 16'(rdy16), 16'd0);
      end else begin
        exp_t e;
        e = q16.pop_front();
        check("res16", r16, e.res);
        check("cout16", 16'(co16), 16'(e.cout));
        check("ovf16", 16'(ov16), 16'(e.ovf));
        check("zero16", 16'(z16), 16'(e.zero));
      end
    end
  end

  // Issues one op, scrambles the operands after the accept edge and measures ready latency.
  task automatic do_op(input bit wide, input logic m, input logic ci,
                       input logic [15:0] aa, input logic [15:0] bb, input exp_t e);
    int lat;
    mode = m;
    c_in = ci;
    a = aa;
    b = bb;
    if (wide) begin
      start16 = 1'b1;
      q16.push_back(e);
    end else begin
      start8 = 1'b1;
      q8.push_back(e);
    end
    @(posedge clk);
    #1;
    check(wide ? "busy16_accept" : "busy8_accept", 16'(wide ? busy16 : busy8), 16'd1);
    start8 = 1'b0;
    start16 = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    mode = 1'($urandom);
    c_in = 1'($urandom);
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (wide ? rdy16 : rdy8) begin
        lat = k;
        break;
      end
    end
    check(wide ? "latency16" : "latency8", 16'(lat), wide ? 16'd4 : 16'd2);
    last_rdy_cyc = cyc;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    exp_t e;
    int   first_rdy;

    vecs[0] = '{1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'hFF, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_res8", {8'h00, r8}, 16'd0);
    check("rst_flags8", {13'd0, co8, ov8, z8}, 16'd0);
    check("rst_busy_ready8", {14'd0, busy8, rdy8}, 16'd0);
    check("rst_res16", r16, 16'd0);
    check("rst_busy_ready16", {14'd0, busy16, rdy16}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      e = '{{8'h00, vecs[i].res}, vecs[i].cout, vecs[i].ovf, vecs[i].zero};
      do_op(1'b0, vecs[i].mode, vecs[i].cin, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, e);
      if (i == 0) first_rdy = last_rdy_cyc;
      if (i == 1) check("back_to_back_gap", 16'(last_rdy_cyc - first_rdy), 16'd3);
    end
    @(posedge clk);
    #1;
    check("hold_res8", {8'h00, r8}, 16'h0000);
    check("hold_flags8", {13'd0, co8, ov8, z8}, 16'h0007);

    // Start pulsed one cycle into CALC must be ignored.
    mode = 1'b0;
    c_in = 1'b0;
    a = 16'h0012;
    b = 16'h0034;
    start8 = 1'b1;
    q8.push_back('{16'h0046, 1'b0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    start8 = 1'b0;
    a = 16'h00FF;
    b = 16'h00FF;
    c_in = 1'b1;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    @(posedge clk);
    #1;
    check("ignored_start_ready", 16'(rdy8), 16'd1);
    repeat (4) @(posedge clk);
    #1;
    check("ignored_start_idle", {14'd0, busy8, rdy8}, 16'd0);

    // Reset during CALC after slice 0 has been written.
    do_op(1'b0, 1'b0, 1'b0, 16'h0080, 16'h0080, '{16'h0000, 1'b1, 1'b1, 1'b1});
    mode = 1'b0;
    c_in = 1'b0;
    a = 16'h0003;
    b = 16'h0004;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    @(posedge clk);
    #1;
    check("mid_busy", 16'(busy8), 16'd1);
    check("mid_partial", {8'h00, r8}, 16'h0007);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy_ready", {14'd0, busy8, rdy8}, 16'd0);
    check("rst_mid_res", {8'h00, r8}, 16'd0);
    check("rst_mid_flags", {13'd0, co8, ov8, z8}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("no_ready_after_rst", {14'd0, busy8, rdy8}, 16'd0);
    @(negedge clk);

    do_op(1'b1, 1'b0, 1'b0, 16'h0FFF, 16'h0001, '{16'h1000, 1'b0, 1'b0, 1'b0});
    do_op(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0001, '{16'h0000, 1'b1, 1'b0, 1'b1});

    for (int i = 0; i < 2000; i++) begin
      logic        m, ci;
      logic [15:0] aa, bb;
      m = 1'($urandom);
      ci = 1'($urandom);
      aa = {8'h00, 8'($urandom)};
      bb = {8'h00, 8'($urandom)};
      do_op(1'b0, m, ci, aa, bb, model(8, m, ci, aa, bb));
    end
    for (int i = 0; i < 10000; i++) begin
      logic        m, ci;
      logic [15:0] aa, bb;
      m = 1'($urandom);
      ci = 1'($urandom);
      aa = 16'($urandom);
      bb = 16'($urandom);
      do_op(1'b1, m, ci, aa, bb, model(16, m, ci, aa, bb));
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue8_drained", 16'(q8.size()), 16'd0);
    check("queue16_drained", 16'(q16.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_addsub_seq.md
# cla_addsub_seq

Parametrised, multi-cycle carry-lookahead adder/subtractor for the datapath of the 8-bit computer. It processes a WIDTH-bit operation one SLICE-bit lookahead group per clock, keeping the inter-slice carry in a register. This keeps the critical path one slice long, independent of WIDTH. A start/busy/ready handshake and registered result flags (carry, signed overflow, zero) let the control unit sequence ALU operations without combinational timing loops.

## Interface
- WIDTH, 8: operand and result width in bits; must be a positive multiple of SLICE.
- SLICE, 4: bits resolved per cycle by one lookahead group; NSLICE = WIDTH/SLICE.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE or DONE.
- mode  input  1  0 = add (A + B + c_in); 1 = subtract (A − B − c_in, c_in acts as borrow-in).
- c_in  input  1  carry-in / borrow-in; latched with start.
- A  input  WIDTH  operand A; latched with start.
- B  input  WIDTH  operand B; latched with start.
- result  output  WIDTH  registered sum/difference.
- c_out  output  1  raw carry out of the MSB slice.
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  result == 0.
- busy  output  1  high while in CALC.
- ready  output  1  one-cycle pulse: result and flags are valid.

## Operation
- Effective operands: Beff = mode ? ~B : B; cin_eff = mode ? ~c_in : c_in. The core computes A + Beff + cin_eff.
- Subtract therefore yields A − B − c_in. In subtract mode, c_out = 1 means no borrow.
- Each slice uses per-bit g = a&b and p = a|b. The slice carries are lookahead-expanded from the slice carry-in (no ripple inside the slice). Sum bit = a^b^carry.
- The slice carry-out is registered as the carry-in of the next slice.
- States:
  - IDLE: the reset state.
  - CALC: a slice counter runs 0..NSLICE−1.
  - DONE: entered after the last slice.
- Transitions:
  - IDLE/DONE --start--> CALC. A, Beff, cin_eff and mode are latched, the counter is cleared, and the result register is cleared.
  - CALC: slice k is written into result[k*SLICE +: SLICE] and the carry register is updated. When k = NSLICE−1, go to DONE.
  - DONE with no start: hold in DONE.
  - DONE with start: same as IDLE with start.
- Flags are written on the final slice edge:
  - c_out = carry out of the last slice.
  - ovf = (A[MSB] == Beff[MSB]) && (result[MSB] != A[MSB]).
  - zero = (full result == 0).
- Result and flags hold until the next accepted start.
- Operand inputs are don't-care after the start edge.
- start while busy = 1 is ignored: no latch, no error, and the current operation is unaffected.

## Timing
- Reset values: state IDLE, result 0, c_out 0, ovf 0, zero 0, busy 0, ready 0, carry register 0, counter 0.
- rst_n low at any time, including mid-CALC, forces all reset values immediately (asynchronous). The operation is abandoned; no ready is produced for it.
- Release from reset is synchronous to the first clk edge with rst_n high.
- Latency: start accepted at edge E. busy = 1 from E to E+NSLICE. ready = 1 for exactly the one cycle following edge E+NSLICE.
- Latency is NSLICE cycles for WIDTH=8, SLICE=4; the result is first usable in cycle E+2.
- Back-to-back issue: start high in the ready cycle is accepted at the next edge. Sustained throughput is one operation per NSLICE+1 cycles.
- While busy, result is partially updated and not valid. Consumers use result/flags only after ready.
- NSLICE = 1 (WIDTH == SLICE) is legal: busy lasts one cycle, and ready follows on the next.

## Test plan
- WIDTH=8, SLICE=4, add, A=0x7F, B=0x01, c_in=0 -> ready exactly 2 cycles after the start edge; result 0x80, c_out 0, ovf 1, zero 0.
- Add, A=0xFF, B=0x01, c_in=1 -> result 0x01, c_out 1, ovf 0. Subtract, A=0x05, B=0x05, c_in=0 -> result 0x00, zero 1, c_out 1.
- Subtract, A=0x00, B=0x01, c_in=0 -> result 0xFF, c_out 0 (borrow), ovf 0. Subtract, A=0x80, B=0x01 -> result 0x7F, ovf 1.
- Handshake: pulse start again one cycle into CALC with different operands -> ignored, original result delivered. Start during the ready cycle -> second op accepted, ready again NSLICE+1 cycles after the first ready.
- Reset mid-op: assert rst_n=0 for one cycle at CALC slice 0 -> busy, ready, result and flags all 0 immediately; no ready afterwards until a new start.
- WIDTH=16, SLICE=4: add 0x0FFF + 0x0001 -> ready 4 cycles after start, result 0x1000, c_out 0. Add 0xFFFF + 0x0001 -> result 0x0000, c_out 1, zero 1. Compare every result against a reference model over 10k random ops in both modes.
